// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the fetch-side program-counter sequencer:
// address width, instruction size, FSM state encoding and default vectors.
package pc_sequencer_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [PC_WIDTH-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC priority selection: trap > misaligned redirect > aligned redirect >
// sequential, merged with any pending event held by the sequencer.
module pc_next_mux
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_sel_boot,
  input  logic                i_sel_seq,
  input  logic                i_sel_evt,
  input  logic                i_trap,
  input  logic                i_redirect_valid,
  input  logic [PC_WIDTH-1:0] i_redirect_target,
  input  logic                i_pend_valid,
  input  logic                i_pend_trap,
  input  logic [PC_WIDTH-1:0] i_pend_target,
  output logic [PC_WIDTH-1:0] o_new_pc,
  output logic                o_evt_valid,
  output logic                o_evt_trap,
  output logic [PC_WIDTH-1:0] o_evt_target,
  output logic                o_misalign
);

  logic w_in_trap;
  logic w_in_redir;

  assign o_misalign = i_redirect_valid && (i_redirect_target[1:0] != 2'b00) && !i_trap;
  assign w_in_trap  = i_trap || o_misalign;
  assign w_in_redir = i_redirect_valid && !w_in_trap;

  // A trap replaces anything; a redirect replaces everything but a pending trap.
  always_comb begin
    o_evt_valid  = i_pend_valid;
    o_evt_trap   = i_pend_trap;
    o_evt_target = i_pend_target;
    if (w_in_trap) begin
      o_evt_valid  = 1'b1;
      o_evt_trap   = 1'b1;
      o_evt_target = TRAP_VECTOR;
    end else if (w_in_redir && !(i_pend_valid && i_pend_trap)) begin
      o_evt_valid  = 1'b1;
      o_evt_trap   = 1'b0;
      o_evt_target = i_redirect_target;
    end
  end

  always_comb begin
    o_new_pc = i_pc;
    if (i_sel_evt && o_evt_valid) begin
      o_new_pc = o_evt_target;
    end else if (i_sel_seq) begin
      o_new_pc = i_pc + PC_WIDTH'(INSTR_BYTES);
    end else if (i_sel_boot) begin
      o_new_pc = RESET_VECTOR;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: drives the next PC every cycle, issues instruction fetches
// and defers redirects/traps that arrive mid-fetch until the fetch drains.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] new_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                trap,
  output logic                instr_valid,
  output logic                misalign_err
);

  seq_state_e          r_state;
  logic                r_imem_req;
  logic                r_pend_valid;
  logic                r_pend_trap;
  logic [PC_WIDTH-1:0] r_pend_target;

  logic                w_fetch_ack;
  logic                w_drain_ack;
  logic                w_sel_evt;
  logic                w_pend_load;
  logic [PC_WIDTH-1:0] w_mux_pc;
  logic                w_evt_valid;
  logic                w_evt_trap;
  logic [PC_WIDTH-1:0] w_evt_target;
  logic                w_misalign;

  assign w_fetch_ack = (r_state == FETCH) && imem_ack;
  assign w_drain_ack = (r_state == DRAIN) && imem_ack;
  assign w_sel_evt   = !rst && ((r_state == BOOT) || (r_state == HOLD) || w_fetch_ack || w_drain_ack);
  // Events arriving while a fetch is outstanding are parked until its ack.
  assign w_pend_load = !rst && !imem_ack && w_evt_valid &&
                       ((r_state == FETCH) || (r_state == DRAIN));

  pc_next_mux #(
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_next_mux (
    .i_pc              (pc),
    .i_sel_boot        (r_state == BOOT),
    .i_sel_seq         (!rst && w_fetch_ack),
    .i_sel_evt         (w_sel_evt),
    .i_trap            (trap),
    .i_redirect_valid  (redirect_valid),
    .i_redirect_target (redirect_target),
    .i_pend_valid      (r_pend_valid),
    .i_pend_trap       (r_pend_trap),
    .i_pend_target     (r_pend_target),
    .o_new_pc          (w_mux_pc),
    .o_evt_valid       (w_evt_valid),
    .o_evt_trap        (w_evt_trap),
    .o_evt_target      (w_evt_target),
    .o_misalign        (w_misalign)
  );

  assign new_pc       = rst ? RESET_VECTOR : w_mux_pc;
  assign imem_req     = r_imem_req && !rst;
  assign imem_addr    = pc;
  assign instr_valid  = !rst && w_fetch_ack && !w_evt_valid;
  assign misalign_err = !rst && w_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= BOOT;
      r_imem_req   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
    end else begin
      case (r_state)
        BOOT, HOLD: begin
          r_state    <= stall ? HOLD : FETCH;
          r_imem_req <= !stall;
        end
        FETCH, DRAIN: begin
          if (imem_ack) begin
            r_state      <= stall ? HOLD : FETCH;
            r_imem_req   <= !stall;
            r_pend_valid <= 1'b0;
            r_pend_trap  <= 1'b0;
          end else if (w_pend_load) begin
            r_state      <= DRAIN;
            r_imem_req   <= 1'b1;
            r_pend_valid <= 1'b1;
            r_pend_trap  <= w_evt_trap;
          end
        end
        default: begin
          r_state    <= BOOT;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_pend_load) begin
      r_pend_target <= w_evt_target;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each row drives one cycle of inputs and
// queues the outputs expected for that cycle, checked at the falling edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        trap;
    logic [31:0] pc;
    logic        req;
    logic        iv;
    logic        me;
    logic [31:0] npc;
  } row_t;

  typedef struct packed {
    logic        req;
    logic        iv;
    logic        me;
    logic [31:0] npc;
    logic [31:0] addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        instr_valid;
  logic        misalign_err;

  int   checks = 0;
  int   errors = 0;
  obs_t sb[$];

  pc_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .new_pc          (new_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .instr_valid     (instr_valid),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(logic r, logic a, logic s, logic v, logic [31:0] t, logic tr,
                              logic [31:0] p, logic q, logic i, logic m, logic [31:0] n);
    row_t x;
    x = '{rst: r, ack: a, stall: s, rv: v, rt: t, trap: tr, pc: p, req: q, iv: i, me: m, npc: n};
    return x;
  endfunction

  task automatic drive(input row_t x);
    obs_t e;
    rst             = x.rst;
    imem_ack        = x.ack;
    stall           = x.stall;
    redirect_valid  = x.rv;
    redirect_target = x.rt;
    trap            = x.trap;
    pc              = x.pc;
    e = '{req: x.req, iv: x.iv, me: x.me, npc: x.npc, addr: x.pc};
    sb.push_back(e);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{req: imem_req, iv: instr_valid, me: misalign_err, npc: new_pc, addr: imem_addr};
    return o;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(1, 1, 0, 0, 32'h0,   0, 32'h40, 0, 0, 0, 32'h0));
    rows.push_back(mk(1, 1, 0, 1, 32'h200, 1, 32'h40, 0, 0, 0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset[%0d] got req=%b iv=%b me=%b npc=%h addr=%h want req=%b iv=%b me=%b npc=%h addr=%h",
                 i, got.req, got.iv, got.me, got.npc, got.addr, exp.req, exp.iv, exp.me, exp.npc, exp.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sequential();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0));
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h4));
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h4, 1, 1, 0, 32'h8));
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h8, 1, 1, 0, 32'hC));
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'hC, 1, 1, 0, 32'h10));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sequential[%0d] got req=%b iv=%b me=%b npc=%h addr=%h want req=%b iv=%b me=%b npc=%h addr=%h",
                 i, got.req, got.iv, got.me, got.npc, got.addr, exp.req, exp.iv, exp.me, exp.npc, exp.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(0, 1, 1, 0, 32'h0, 0, 32'h10, 1, 1, 0, 32'h14));
    rows.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h14, 0, 0, 0, 32'h14));
    rows.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h14, 0, 0, 0, 32'h14));
    rows.push_back(mk(0, 0, 0, 0, 32'h0, 0, 32'h14, 0, 0, 0, 32'h14));
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h14, 1, 1, 0, 32'h18));
    // Fetch waiting for ack ignores stall and holds the address.
    rows.push_back(mk(0, 0, 1, 0, 32'h0, 0, 32'h18, 1, 0, 0, 32'h18));
    rows.push_back(mk(0, 1, 0, 0, 32'h0, 0, 32'h18, 1, 1, 0, 32'h1C));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stall[%0d] got req=%b iv=%b me=%b npc=%h addr=%h want req=%b iv=%b me=%b npc=%h addr=%h",
                 i, got.req, got.iv, got.me, got.npc, got.addr, exp.req, exp.iv, exp.me, exp.npc, exp.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(0, 1, 0, 1, 32'h200, 0, 32'h1C,  1, 0, 0, 32'h200));
    // Redirect without ack parks in DRAIN; a later trap wins over it and a
    // later redirect cannot displace the trap.
    rows.push_back(mk(0, 0, 0, 1, 32'h200, 0, 32'h200, 1, 0, 0, 32'h200));
    rows.push_back(mk(0, 0, 0, 0, 32'h0,   1, 32'h200, 1, 0, 0, 32'h200));
    rows.push_back(mk(0, 0, 0, 1, 32'h300, 0, 32'h200, 1, 0, 0, 32'h200));
    rows.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h200, 1, 0, 0, 32'h100));
    // A newer redirect replaces a pending redirect.
    rows.push_back(mk(0, 0, 0, 1, 32'h400, 0, 32'h100, 1, 0, 0, 32'h100));
    rows.push_back(mk(0, 0, 0, 1, 32'h500, 0, 32'h100, 1, 0, 0, 32'h100));
    rows.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h100, 1, 0, 0, 32'h500));
    rows.push_back(mk(0, 1, 0, 1, 32'h202, 0, 32'h500, 1, 0, 1, 32'h100));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL redirect[%0d] got req=%b iv=%b me=%b npc=%h addr=%h want req=%b iv=%b me=%b npc=%h addr=%h",
                 i, got.req, got.iv, got.me, got.npc, got.addr, exp.req, exp.iv, exp.me, exp.npc, exp.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap_reset();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 32'h100,        1, 0, 0, 32'hFFFF_FFFC));
    rows.push_back(mk(0, 1, 0, 0, 32'h0,         0, 32'hFFFF_FFFC,  1, 1, 0, 32'h0));
    rows.push_back(mk(0, 0, 0, 1, 32'h200,       0, 32'h0,          1, 0, 0, 32'h0));
    rows.push_back(mk(1, 0, 0, 0, 32'h0,         0, 32'h0,          0, 0, 0, 32'h0));
    // Late ack in BOOT is ignored and the abandoned redirect never lands.
    rows.push_back(mk(0, 1, 0, 0, 32'h0,         0, 32'h44,         0, 0, 0, 32'h0));
    rows.push_back(mk(0, 1, 0, 0, 32'h0,         0, 32'h0,          1, 1, 0, 32'h4));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_reset[%0d] got req=%b iv=%b me=%b npc=%h addr=%h want req=%b iv=%b me=%b npc=%h addr=%h",
                 i, got.req, got.iv, got.me, got.npc, got.addr, exp.req, exp.iv, exp.me, exp.npc, exp.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    obs_t got, exp;
    rows.push_back(mk(0, 1, 1, 0, 32'h0,   0, 32'h4,   1, 1, 0, 32'h8));
    rows.push_back(mk(0, 0, 0, 1, 32'h206, 0, 32'h8,   0, 0, 1, 32'h100));
    rows.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h100, 1, 1, 0, 32'h104));
    rows.push_back(mk(0, 1, 0, 1, 32'h300, 1, 32'h104, 1, 0, 0, 32'h100));
    rows.push_back(mk(0, 1, 0, 0, 32'h0,   0, 32'h100, 1, 1, 0, 32'h104));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d] got req=%b iv=%b me=%b npc=%h addr=%h want req=%b iv=%b me=%b npc=%h addr=%h",
                 i, got.req, got.iv, got.me, got.npc, got.addr, exp.req, exp.iv, exp.me, exp.npc, exp.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst             = 1'b1;
    pc              = 32'h0;
    imem_ack        = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap            = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the target on trap or misaligned redirect.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pc, input, 32 bits: current value of the program-counter register.
REQ-006 SHALL have port new_pc, output, 32 bits: next value loaded into the program-counter register every cycle.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction-fetch request.
REQ-008 SHALL have port imem_addr, output, 32 bits: fetch address.
REQ-009 SHALL have port imem_ack, input, 1 bit: fetch completion, valid only while imem_req=1.
REQ-010 SHALL have port stall, input, 1 bit: downstream cannot accept an instruction.
REQ-011 SHALL have ports redirect_valid (input, 1 bit) and redirect_target (input, 32 bits): branch or jump request from execute.
REQ-012 SHALL have port trap, input, 1 bit: exception request.
REQ-013 SHALL have port instr_valid, output, 1 bit: 1-cycle pulse marking an accepted fetch.
REQ-014 SHALL have port misalign_err, output, 1 bit: 1-cycle pulse when a redirect_target has bits [1:0] != 0.

Function
REQ-015 SHALL implement FSM states BOOT, FETCH, HOLD and DRAIN.
REQ-016 SHALL drive new_pc = pc in every cycle not otherwise specified, because the program-counter register has no enable.
REQ-017 SHALL drive imem_addr = pc whenever imem_req=1, stable until ack.
REQ-018 BOOT: imem_req=0; new_pc=RESET_VECTOR; next state is HOLD if stall=1, else FETCH.
REQ-019 FETCH: imem_req=1; on imem_ack=1 with no redirect or trap, instr_valid=1 and new_pc=pc+4; next state is HOLD if stall=1, else FETCH.
REQ-020 FETCH with imem_ack=0: stall is ignored; new_pc=pc.
REQ-021 HOLD: imem_req=0; new_pc=pc; when stall=0, next state is FETCH.
REQ-022 Redirect/trap priority SHALL be trap > misaligned redirect (treated as trap, misalign_err=1) > aligned redirect > sequential.
REQ-023 Redirect or trap in BOOT, HOLD, or in FETCH with imem_ack=1: new_pc=target immediately; instr_valid=0 (squash); next state per stall as in REQ-019.
REQ-024 Redirect or trap in FETCH with imem_ack=0: target latched in a pending register; new_pc=pc; next state DRAIN.
REQ-025 DRAIN: imem_req stays 1 at the unchanged address; on imem_ack, data is discarded (instr_valid=0), new_pc=pending target, and the pending register is cleared; next state is HOLD if stall=1, else FETCH.
REQ-026 Pending-register update in DRAIN: a newer redirect overwrites a pending redirect; a trap overwrites anything; a redirect SHALL NOT overwrite a pending trap.
REQ-027 Arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-028 Outputs instr_valid and misalign_err SHALL never be asserted when imem_req=0, except for misalign_err in BOOT or HOLD.

Reset
REQ-029 While rst=1: state=BOOT, imem_req=0, instr_valid=0, misalign_err=0, pending cleared, new_pc=RESET_VECTOR.
REQ-030 rst mid-request (FETCH or DRAIN) SHALL abandon the request; any late imem_ack in BOOT SHALL be ignored.

Structure
REQ-031 The shared CPU package SHALL hold PC_WIDTH=32, INSTR_BYTES=4, the state enumeration, and the default RESET_VECTOR and TRAP_VECTOR.
REQ-032 The next-PC priority selection SHALL be one combinational sub-module, pc_next_mux; the FSM and pending register stay in pc_sequencer.

Verification
REQ-033 Reset release, pc=0, ack every cycle -> BOOT new_pc=0; pc sequence 0, 4, 8, 12 with instr_valid=1 each cycle.
REQ-034 Ack in FETCH with stall=1 for 3 cycles -> HOLD; imem_req=0 and new_pc=pc for 3 cycles; resumes fetching at pc+4.
REQ-035 redirect_target=32'h200 with ack in the same cycle -> instr_valid=0 and new_pc=32'h200.
REQ-036 Redirect 32'h200 while ack=0, then trap, then ack 2 cycles later -> DRAIN with address unchanged; new_pc=32'h100 and instr_valid=0.
REQ-037 redirect_target=32'h202 -> misalign_err=1 and new_pc=32'h100.
REQ-038 pc=32'hFFFF_FFFC with ack -> new_pc=0; rst asserted in DRAIN -> imem_req=0 next cycle and new_pc=RESET_VECTOR.
